wb_layer_sequencer: RTL and testbench

WB_LAYER_SEQUENCER -- requirements
Module: wb_layer_sequencer

---
 rtl/wb_layer_sequencer_if.sv | 16 +
 rtl/wb_layer_sequencer.sv | 112 +++++++++++
 tb/tb_wb_layer_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_layer_sequencer_if.sv
// Config-word stream toward the weight/bias separator plus its state feedback.
interface wb_layer_sequencer_if;
  logic        m_axis_wbconfig_tvalid;
  logic        m_axis_wbconfig_tready;
  logic [31:0] m_axis_wbconfig_tdata;
  logic [3:0]  status_wbs;

  modport master (
    output m_axis_wbconfig_tvalid, m_axis_wbconfig_tdata,
    input  m_axis_wbconfig_tready, status_wbs
  );
  modport slave (
    input  m_axis_wbconfig_tvalid, m_axis_wbconfig_tdata,
    output m_axis_wbconfig_tready, status_wbs
  );
endinterface

// File: rtl/wb_layer_sequencer.sv
// Walks a descriptor table, emitting two config words per layer and, for PS-sourced
// layers, waiting for the separator to run a transfer before moving on.
module wb_layer_sequencer #(
  parameter int MAX_LAYERS     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int AW  = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tbl_wr_en,
  input  logic [AW-1:0]          tbl_wr_addr,
  input  logic [63:0]            tbl_wr_data,
  input  logic                   start,
  input  logic [AW:0]            num_layers,
  wb_layer_sequencer_if.master   wb,
  output logic                   busy,
  output logic [AW-1:0]          cur_layer,
  output logic                   layer_done,
  output logic                   run_done,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CFG0, S_CFG1, S_WAIT_START, S_WAIT_DONE, S_NEXT, S_FINISH
  } state_t;

  state_t           state, state_nx;
  logic [63:0]      tbl [MAX_LAYERS];
  logic [63:0]      desc_q;
  logic [AW:0]      nl_q;
  logic [WDW-1:0]   wd;
  logic             in_wait, wd_expired, last;

  assign in_wait    = (state == S_WAIT_START) || (state == S_WAIT_DONE);
  assign wd_expired = (wd == WDW'(TIMEOUT_CYCLES - 1));
  assign last       = (({1'b0, cur_layer} + (AW+1)'(1)) == nl_q);

  // Table has no reset; it must be rewritten after rst anyway.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && !busy) tbl[tbl_wr_addr] <= tbl_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (start) state_nx = (num_layers == '0) ? S_FINISH : S_LOAD;
      S_LOAD:       state_nx = S_CFG0;
      S_CFG0:       if (wb.m_axis_wbconfig_tready) state_nx = S_CFG1;
      S_CFG1:       if (wb.m_axis_wbconfig_tready) state_nx = desc_q[63] ? S_WAIT_START : S_NEXT;
      S_WAIT_START: if (wb.status_wbs != '0) state_nx = S_WAIT_DONE;
                    else if (wd_expired)     state_nx = S_FINISH;
      S_WAIT_DONE:  if (wb.status_wbs == '0) state_nx = S_NEXT;
                    else if (wd_expired)     state_nx = S_FINISH;
      S_NEXT:       state_nx = last ? S_FINISH : S_LOAD;
      S_FINISH:     state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Words come straight from the latched descriptor, so they hold while stalled.
  always_comb begin
    wb.m_axis_wbconfig_tvalid = 1'b0;
    wb.m_axis_wbconfig_tdata  = '0;
    case (state)
      S_CFG0: begin
        wb.m_axis_wbconfig_tvalid = 1'b1;
        wb.m_axis_wbconfig_tdata  = desc_q[63:32];
      end
      S_CFG1: begin
        wb.m_axis_wbconfig_tvalid = 1'b1;
        wb.m_axis_wbconfig_tdata  = desc_q[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      cur_layer   <= '0;
      nl_q        <= '0;
      desc_q      <= '0;
      wd          <= '0;
      layer_done  <= 1'b0;
      run_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy       <= (state_nx != S_IDLE);
      layer_done <= (state_nx == S_NEXT);
      // run_done lands in the first idle cycle, together with busy falling
      run_done   <= (state == S_FINISH);
      if (state == S_IDLE && start) begin
        timeout_err <= 1'b0;
        cur_layer   <= '0;
        nl_q        <= (num_layers > (AW+1)'(MAX_LAYERS)) ? (AW+1)'(MAX_LAYERS) : num_layers;
      end
      if (state == S_LOAD) desc_q <= tbl[cur_layer];
      if (state == S_NEXT && !last) cur_layer <= cur_layer + 1'b1;
      if (in_wait && state_nx == S_FINISH) timeout_err <= 1'b1;
      // Watchdog restarts on every entry into a wait state.
      if (!in_wait || state_nx != state) wd <= '0;
      else                               wd <= wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_layer_sequencer.sv
// Scoreboarded bench: a table-walking reference model queues expected words/events,
// a negedge monitor pops and compares whatever the sequencer presents.
module tb_wb_layer_sequencer;
  localparam int ML = 8;
  localparam int TO = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_wr_en;
  logic [AW-1:0] tbl_wr_addr;
  logic [63:0]   tbl_wr_data;
  logic          start;
  logic [AW:0]   num_layers;
  logic          busy, layer_done, run_done, timeout_err;
  logic [AW-1:0] cur_layer;

  wb_layer_sequencer_if bus();

  wb_layer_sequencer #(.MAX_LAYERS(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .start(start), .num_layers(num_layers), .wb(bus),
    .busy(busy), .cur_layer(cur_layer), .layer_done(layer_done),
    .run_done(run_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic [63:0] mtbl [ML];
  logic [31:0] q_word [$];
  int          q_layer [$];
  bit          q_run [$];
  int tr_mode = 1;    // 0 random, 1 high, 2 low
  int resp_mode = 0;  // 0 normal transfer, 1 never respond, 2 hang busy
  int ps_req = 0, ps_ack = 0;
  int cyc = 0, ld_cnt = 0, run_cnt = 0, last_hs2 = 0, phase = 0;
  logic [31:0] hi_w;
  bit pl_chk = 0;
  logic to_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // Reference: walk the table, two words per layer, PS layers stall forever if stuck.
  task automatic model_run(input int n, input bit stuck);
    int m;
    bit to;
    m  = (n > ML) ? ML : n;
    to = 1'b0;
    for (int i = 0; i < m; i++) begin
      q_word.push_back(mtbl[i][63:32]);
      q_word.push_back(mtbl[i][31:0]);
      if (mtbl[i][63] && stuck) begin
        to = 1'b1;
        break;
      end
      q_layer.push_back(i);
    end
    q_run.push_back(to);
  endtask

  // tready driver
  initial begin
    bus.m_axis_wbconfig_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       bus.m_axis_wbconfig_tready = ($urandom % 4) != 0;
        1:       bus.m_axis_wbconfig_tready = 1'b1;
        default: bus.m_axis_wbconfig_tready = 1'b0;
      endcase
    end
  end

  // Separator model: runs a 0->1->2->0 transfer for each PS layer
  initial begin
    bus.status_wbs = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (resp_mode == 2) begin
        if (ps_req != ps_ack) begin
          ps_ack = ps_req;
          bus.status_wbs = 4'd1;
        end
      end else begin
        bus.status_wbs = 4'd0;
        if (ps_req != ps_ack) begin
          ps_ack = ps_req;
          if (resp_mode == 0) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.status_wbs = 4'd1;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            bus.status_wbs = 4'd2;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            bus.status_wbs = 4'd0;
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      phase  = 0;
      pl_chk = 0;
      ps_req = ps_ack;
      to_prev = 1'b0;
    end else begin
      if (pl_chk) begin
        chk("pl_layer_done_latency", layer_done, 1);
        pl_chk = 0;
      end
      if (bus.m_axis_wbconfig_tvalid && bus.m_axis_wbconfig_tready) begin
        if (q_word.size() == 0) fail("unexpected_cfg_word");
        else chk("cfg_word", bus.m_axis_wbconfig_tdata, q_word.pop_front());
        if (phase == 0) hi_w = bus.m_axis_wbconfig_tdata;
        else begin
          last_hs2 = cyc;
          if (hi_w[31]) ps_req++;
          else pl_chk = 1;
        end
        phase ^= 1;
      end
      if (layer_done) begin
        ld_cnt++;
        if (q_layer.size() == 0) fail("unexpected_layer_done");
        else chk("layer_done_index", cur_layer, q_layer.pop_front());
      end
      if (run_done) begin
        run_cnt++;
        chk("busy_low_at_run_done", busy, 0);
        if (q_run.size() == 0) fail("unexpected_run_done");
        else chk("run_timeout_flag", timeout_err, q_run.pop_front());
      end
      if (timeout_err && !to_prev) chk("timeout_latency", cyc - last_hs2, TO + 1);
      to_prev = timeout_err;
    end
  end

  task automatic tbl_write(input int a, input logic [63:0] d, input bit upd);
    @(posedge clk); #1;
    tbl_wr_en = 1'b1; tbl_wr_addr = AW'(a); tbl_wr_data = d;
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
    if (upd) mtbl[a] = d;
  endtask

  task automatic start_pulse(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_layers = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_clears_timeout", timeout_err, 0);
    chk("busy_after_start", busy, 1);
    if (n != 0) chk("tvalid_low_in_load", bus.m_axis_wbconfig_tvalid, 0);
    else        chk("run_done_not_early", run_done, 0);
    @(negedge clk);
    if (n != 0) chk("start_to_tvalid_2cyc", bus.m_axis_wbconfig_tvalid, 1);
    else        chk("zero_layers_run_done_2cyc", run_done, 1);
  endtask

  task automatic wait_runs(input int target);
    int k;
    k = 0;
    while (run_cnt < target && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (run_cnt < target) chk("run_done_wait", run_cnt, target);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit stuck);
    int t;
    t = run_cnt + 1;
    model_run(n, stuck);
    start_pulse(n);
    wait_runs(t);
  endtask

  initial begin
    int t, k, l0, r0;
    rst = 1'b1; start = 1'b0; num_layers = '0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", bus.m_axis_wbconfig_tvalid, 0);
    chk("rst_tdata", bus.m_axis_wbconfig_tdata, 0);
    chk("rst_cur_layer", cur_layer, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Two PS layers
    tbl_write(0, 64'h80000100_00000800, 1);
    tbl_write(1, 64'h80000040_00000200, 1);
    run(2, 0);
    chk("busy_after_ps_run", busy, 0);

    // One PL layer
    tbl_write(0, 64'h00000100_00000800, 1);
    run(1, 0);

    // Stall in CFG0, plus start and table write while busy
    tbl_write(0, 64'h80000100_00000800, 1);
    tr_mode = 2;
    t = run_cnt + 1;
    model_run(1, 0);
    start_pulse(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_tvalid", bus.m_axis_wbconfig_tvalid, 1);
      chk("stall_tdata", bus.m_axis_wbconfig_tdata, 32'h80000100);
    end
    @(posedge clk); #1 start = 1'b1; num_layers = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    tbl_write(0, 64'h12345678_9abcdef0, 0);
    @(negedge clk);
    chk("busy_start_ignored_tdata", bus.m_axis_wbconfig_tdata, 32'h80000100);
    chk("busy_start_ignored_layer", cur_layer, 0);
    tr_mode = 0;
    wait_runs(t);
    run(1, 0);

    // Zero layers
    run(0, 0);
    chk("busy_after_zero_run", busy, 0);

    // Watchdog: layer 1 is PS and the separator never responds
    tbl_write(0, {1'b0, 31'($urandom), 32'($urandom)}, 1);
    tbl_write(1, {1'b1, 31'($urandom), 32'($urandom)}, 1);
    tbl_write(2, {1'b0, 31'($urandom), 32'($urandom)}, 1);
    resp_mode = 1;
    run(3, 1);
    chk("timeout_sticky", timeout_err, 1);
    chk("timeout_cur_layer_held", cur_layer, 1);
    resp_mode = 0;

    // Random runs, including clamping above ML
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < ML; i++)
        tbl_write(i, {1'($urandom), 31'($urandom), 32'($urandom)}, 1);
      run((r == 7) ? 15 : $urandom_range(1, 12), 0);
    end
    chk("final_layer_held", cur_layer, ML - 1);

    // Reset during WAIT_DONE of layer 1
    tr_mode = 1;
    tbl_write(0, {1'b1, 31'($urandom), 32'($urandom)}, 1);
    tbl_write(1, {1'b1, 31'($urandom), 32'($urandom)}, 1);
    model_run(2, 0);
    start_pulse(2);
    l0 = ld_cnt; k = 0;
    while (ld_cnt == l0 && k < 200) begin @(negedge clk); k++; end
    resp_mode = 2;
    k = 0;
    while (bus.status_wbs != 4'd1 && k < 200) begin @(negedge clk); k++; end
    chk("hang_reached", bus.status_wbs, 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tvalid", bus.m_axis_wbconfig_tvalid, 0);
    chk("async_rst_tdata", bus.m_axis_wbconfig_tdata, 0);
    chk("async_rst_cur_layer", cur_layer, 0);
    chk("async_rst_layer_done", layer_done, 0);
    q_word.delete(); q_layer.delete(); q_run.delete();
    resp_mode = 0;
    r0 = run_cnt;
    tbl_write(0, {1'b0, 31'($urandom), 32'($urandom)}, 1);
    tbl_write(1, {1'b1, 31'($urandom), 32'($urandom)}, 1);
    chk("no_run_done_on_reset", run_cnt, r0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; num_layers = 4'd2;
    model_run(2, 0);
    t = run_cnt + 1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("rerun_from_layer0", cur_layer, 0);
    chk("rerun_busy", busy, 1);
    wait_runs(t);

    chk("words_drained", q_word.size(), 0);
    chk("layers_drained", q_layer.size(), 0);
    chk("runs_drained", q_run.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
